// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences multi-cycle data-memory accesses for the MEM stage.
// The pipeline is held while an access is outstanding. The returned load data is
// handed to MEM/WB for one advance cycle. Every access ends after at most TIMEOUT
// cycles, so a missing ack cannot hang the pipeline.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] read_data_out,
  output logic        pipe_stall,
  output logic        wb_bubble,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic               req_p;

  assign req_p = mem_read_in | mem_write_in;

  // Freeze the front of the pipe from the request cycle until the access resolves.
  assign pipe_stall = ((state_q == IDLE) && req_p) || (state_q == ACCESS);
  assign wb_bubble  = pipe_stall;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (req_p) begin
          we_d    = mem_write_in;
          addr_d  = addr_in;
          wdata_d = wdata_in;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack takes priority over the timeout in the same cycle.
        if (dmem_ack) begin
          if (!we_q) rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = DONE;
        end
      end
      // The same instruction is still in EX/MEM here, so its request is not restarted.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == ACCESS);
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign read_data_out = rdata_q;
  assign busy          = busy_q;
  assign timeout_err   = terr_q;

endmodule
